// File: rtl/bus_map_pkg.sv
// ============================================================================
// Module      : bus_map_pkg
// Description : Address map, STATUS bit layout and serializer states for the
//               data-side bus target.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_map_pkg;

    localparam logic [31:0] IO_BASE     = 32'h8000_0000;
    localparam logic [31:0] ADDR_GPIO   = 32'h8000_0000;
    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0001;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0002;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0003;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_buf.sv
// ============================================================================
// Module      : uart_tx_buf
// Description : TX FIFO feeding an 8N1 LSB-first serializer with a registered,
//               idle-high serial output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buf
    import bus_map_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    localparam int PTR_W       = $clog2(FIFO_DEPTH),
    localparam int CNT_W       = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             tx
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              w_push_ok;
    logic              w_pop;
    logic              w_bit_done;

    assign full       = (r_count == CNT_W'(FIFO_DEPTH));
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign busy       = (r_state != SER_IDLE);
    assign tx         = r_tx;
    assign w_push_ok  = push && !full;
    assign w_bit_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            SER_IDLE: begin
                if (!empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SER_START;
                end
            end
            SER_START: begin
                if (w_bit_done) w_state_nxt = SER_DATA;
            end
            SER_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) w_state_nxt = SER_STOP;
            end
            SER_STOP: begin
                // Pop on the stop-bit boundary so queued bytes go out back-to-back.
                if (w_bit_done) begin
                    if (!empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = SER_START;
                    end else begin
                        w_state_nxt = SER_IDLE;
                    end
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_pop) begin
            w_shift_nxt = r_fifo[r_rd_ptr];
        end else if ((r_state == SER_DATA) && w_bit_done) begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
        end
        case (w_state_nxt)
            SER_START: w_tx_nxt = 1'b0;
            SER_DATA:  w_tx_nxt = w_shift_nxt[0];
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SER_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx      <= 1'b1;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_tx    <= w_tx_nxt;
            r_shift <= w_shift_nxt;
            if ((r_state == SER_IDLE) || w_bit_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (r_state == SER_START) begin
                r_bit_idx <= '0;
            end else if ((r_state == SER_DATA) && w_bit_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_fifo[r_wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/data_bus_ctrl.sv
// ============================================================================
// Module      : data_bus_ctrl
// Description : CPU data-side bus target: RAM, GPIO, buffered UART TX, STATUS
//               and cycle counter behind a combinational read mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_ctrl
    import bus_map_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int RAM_WORDS    = 1024,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic              read,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [15:0]       gpio_out,
    output logic              uart_tx
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] r_ram [RAM_WORDS];
    logic [15:0]       r_gpio;
    logic              r_ovf;
    logic [31:0]       r_cycle;

    logic              w_is_ram;
    logic              w_sel_gpio;
    logic              w_sel_tx;
    logic              w_sel_status;
    logic              w_sel_cycle;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_tx_push;
    logic              w_full;
    logic              w_empty;
    logic              w_busy;
    logic [CNT_W-1:0]  w_count;
    logic [31:0]       w_status;
    logic              w_unused;

    // Reads carry no side effects, so the strobe itself is not needed.
    assign w_unused = read;

    // The whole lower half of the space mirrors the RAM.
    assign w_is_ram     = (address < ADDR_W'(IO_BASE));
    assign w_sel_gpio   = (address == ADDR_W'(ADDR_GPIO));
    assign w_sel_tx     = (address == ADDR_W'(ADDR_TXDATA));
    assign w_sel_status = (address == ADDR_W'(ADDR_STATUS));
    assign w_sel_cycle  = (address == ADDR_W'(ADDR_CYCLE));
    assign w_ram_idx    = address[RAM_AW-1:0];
    assign w_tx_push    = write && w_sel_tx;
    assign gpio_out     = r_gpio;

    uart_tx_buf #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (wdata[7:0]),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .busy      (w_busy),
        .tx        (uart_tx)
    );

    always_comb begin
        w_status                                = '0;
        w_status[STAT_FULL]                     = w_full;
        w_status[STAT_EMPTY]                    = w_empty;
        w_status[STAT_BUSY]                     = w_busy;
        w_status[STAT_OVF]                      = r_ovf;
        w_status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(w_count);
    end

    always_comb begin
        rdata = '0;
        if (w_is_ram) begin
            rdata = r_ram[w_ram_idx];
        end else if (w_sel_gpio) begin
            rdata = DATA_W'(r_gpio);
        end else if (w_sel_status) begin
            rdata = DATA_W'(w_status);
        end else if (w_sel_cycle) begin
            rdata = DATA_W'(r_cycle);
        end
    end

    always_ff @(posedge clk) begin
        if (write && w_is_ram) r_ram[w_ram_idx] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gpio  <= '0;
            r_ovf   <= 1'b0;
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (write && w_sel_gpio) r_gpio <= wdata[15:0];
            // Full is judged on the pre-edge count, even if a pop happens now.
            if (write && w_sel_status) begin
                r_ovf <= 1'b0;
            end else if (w_tx_push && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_ctrl.sv
// ============================================================================
// Module      : tb_data_bus_ctrl
// Description : Scoreboard bench for data_bus_ctrl: random bus traffic against a
//               behavioural model plus directed UART, FIFO and reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus_ctrl;
    import bus_map_pkg::*;

    localparam int RW  = 1024;
    localparam int CPB = 4;
    localparam int FD  = 8;

    logic        clk;
    logic        rst;
    logic        write;
    logic        read;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] gpio_out;
    logic        uart_tx;

    data_bus_ctrl #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .RAM_WORDS    (RW),
        .FIFO_DEPTH   (FD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (write),
        .read     (read),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .gpio_out (gpio_out),
        .uart_tx  (uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] m_ram [int];
    logic [15:0] m_gpio;
    logic [31:0] tb_cyc;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        frame_abort = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Cycles elapsed since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    always @(posedge rst) frame_abort = 1'b1;

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a < IO_BASE)          return m_ram[int'(a % RW)];
        else if (a == ADDR_GPIO)  return {16'h0, m_gpio};
        else if (a == ADDR_CYCLE) return tb_cyc;
        else                      return 32'h0;
    endfunction

    task automatic cyc_write(input logic [31:0] a, input logic [31:0] d);
        write   = 1'b1;
        read    = 1'b0;
        address = a;
        wdata   = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        if (a < IO_BASE)         m_ram[int'(a % RW)] = d;
        else if (a == ADDR_GPIO) m_gpio = d[15:0];
    endtask

    task automatic cyc_read(input logic [31:0] a, input logic [31:0] exp);
        read    = 1'b1;
        write   = 1'b0;
        address = a;
        rd_q.push_back('{a, exp});
        @(posedge clk);
        #1;
        read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cycle-exact serial waveform after a push into an idle transmitter.
    task automatic check_wave(input logic [7:0] b);
        logic exp;
        int   bi;
        for (int j = 0; j <= 10 * CPB + 1; j++) begin
            @(negedge clk);
            if (j == 0 || j > 10 * CPB) begin
                exp = 1'b1;
            end else begin
                bi  = (j - 1) / CPB;
                exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            end
            chk($sformatf("tx wave %0d", j), {31'h0, uart_tx}, {31'h0, exp});
        end
        @(posedge clk);
        #1;
    endtask

    // Read monitor: every sampled read pops the oldest expectation.
    always @(negedge clk) begin
        rd_exp_t e;
        if (read && !rst) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL read scoreboard: got read of 0x%08h expected none", address);
            end else begin
                e = rd_q.pop_front();
                chk($sformatf("read 0x%08h", e.addr), rdata, e.exp);
            end
        end
    end

    // Serial monitor: decodes each frame at bit centres.
    initial begin
        logic [7:0] b;
        logic       sb;
        logic       pb;
        logic [7:0] e;
        forever begin
            @(negedge uart_tx);
            if (rst) continue;
            frame_abort = 1'b0;
            repeat (CPB / 2) @(negedge clk);
            sb = uart_tx;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                b[k] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            pb = uart_tx;
            if (!frame_abort) begin
                if (tx_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL uart frame: got byte 0x%02h expected no frame", b);
                end else begin
                    e = tx_q.pop_front();
                    chk("uart byte", {24'h0, b}, {24'h0, e});
                    chk("uart start bit", {31'h0, sb}, 32'h0);
                    chk("uart stop bit", {31'h0, pb}, 32'h1);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [7:0]  bt;
        int          lows;

        rst     = 1'b1;
        write   = 1'b0;
        read    = 1'b0;
        address = 32'h0;
        wdata   = 32'h0;
        m_gpio  = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("gpio_out after reset", {16'h0, gpio_out}, 32'h0);
        chk("uart_tx after reset", {31'h0, uart_tx}, 32'h1);
        chk("cycle small after reset", {31'h0, tb_cyc <= 32'd2}, 32'h1);
        cyc_read(ADDR_CYCLE, model_rd(ADDR_CYCLE));
        cyc_read(ADDR_STATUS, 32'h0000_0002);
        cyc_read(ADDR_TXDATA, 32'h0);

        cyc_write(ADDR_GPIO, 32'hFFFF_A5A5);
        chk("gpio_out after write", {16'h0, gpio_out}, 32'h0000_A5A5);
        cyc_read(ADDR_GPIO, 32'h0000_A5A5);
        cyc_read(32'h8000_0010, 32'h0);
        cyc_write(32'h8000_0010, 32'h1234_5678);
        cyc_read(32'h8000_0010, 32'h0);
        cyc_read(ADDR_GPIO, 32'h0000_A5A5);

        // Asynchronous reset in the middle of a clock phase.
        #2 rst = 1'b1;
        #1;
        chk("gpio_out async reset", {16'h0, gpio_out}, 32'h0);
        chk("uart_tx async reset", {31'h0, uart_tx}, 32'h1);
        m_gpio = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc_read(ADDR_CYCLE, model_rd(ADDR_CYCLE));
        cyc_read(ADDR_STATUS, 32'h0000_0002);

        cyc_write(32'h5, 32'hDEAD_BEEF);
        cyc_write(32'h405, 32'h1234_5678);
        cyc_read(32'h5, 32'h1234_5678);
        cyc_write(32'h6, 32'h0);
        cyc_read(32'h6, 32'h0);

        for (int k = 0; k < 16; k++) cyc_write(k, $urandom);
        for (int i = 0; i < 200; i++) begin
            a = 32'($urandom_range(0, 15)) + RW * 32'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0, 1: cyc_write(a, $urandom);
                2, 3: cyc_read(a, model_rd(a));
                4:    cyc_write(ADDR_GPIO, $urandom);
                5:    cyc_read(ADDR_GPIO, model_rd(ADDR_GPIO));
                6: begin
                    a = 32'h8000_0004 + 32'($urandom_range(0, 4000));
                    if ($urandom_range(0, 1) == 1) cyc_write(a, $urandom);
                    else                          cyc_read(a, 32'h0);
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) cyc_read(ADDR_CYCLE, model_rd(ADDR_CYCLE));
                    else                          cyc_read(ADDR_TXDATA, 32'h0);
                end
            endcase
        end
        cyc_read(ADDR_STATUS, 32'h0000_0002);

        tx_q.push_back(8'h55);
        cyc_write(ADDR_TXDATA, 32'h0000_0055);
        check_wave(8'h55);
        cyc_read(ADDR_STATUS, 32'h0000_0002);

        tx_q.push_back(8'h3C);
        cyc_write(ADDR_TXDATA, 32'h0000_003C);
        cyc_read(ADDR_STATUS, 32'h0000_0010);
        cyc_read(ADDR_STATUS, 32'h0000_0006);
        idle(10 * CPB + 5);

        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_q.push_back(8'(i));
            cyc_write(ADDR_TXDATA, 32'(i));
        end
        cyc_read(ADDR_STATUS, 32'h0000_008D);
        cyc_write(ADDR_STATUS, 32'h0);
        cyc_read(ADDR_STATUS, 32'h0000_0085);
        idle(9 * 10 * CPB + 20);
        cyc_read(ADDR_STATUS, 32'h0000_0002);

        for (int i = 0; i < 3; i++) begin
            bt = 8'($urandom);
            tx_q.push_back(bt);
            cyc_write(ADDR_TXDATA, {24'h0, bt});
            idle(10 * CPB + 5);
        end

        cyc_write(ADDR_TXDATA, 32'h0000_00A3);
        idle(18);
        chk("uart_tx in data bit 3", {31'h0, uart_tx}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("uart_tx mid-frame reset", {31'h0, uart_tx}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc_read(ADDR_STATUS, 32'h0000_0002);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("uart_tx quiet after reset", 32'(lows), 32'h0);
        idle(5);

        chk("uart frames outstanding", 32'(tx_q.size()), 32'h0);
        chk("reads outstanding", 32'(rd_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_bus_ctrl.md
# data_bus_ctrl

Data-side bus target for the CPU core: receives the core's registered `write`/`read`/`address`/`dout` request and returns read data on the core's `din`. It decodes one word-addressed space into a data RAM and four memory-mapped registers: GPIO out, UART TX data, UART status and cycle counter. It also holds a buffered UART transmitter that drains a TX FIFO onto a serial pin.

## Interface
Parameters:
- `ADDR_W`, 32: address width (matches `MemAddrBus`).
- `DATA_W`, 32: data width (matches `MemBusWidth`).
- `RAM_WORDS`, 1024: RAM depth in words, power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two.
- `CLKS_PER_BIT`, 868: clocks per UART bit, ≥ 2.

Ports:
- `clk`, in, 1: the block's one clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `write`, in, 1: CPU write request; performed at the next `clk` edge.
- `read`, in, 1: CPU read request.
- `address`, in, `ADDR_W`: word address.
- `wdata`, in, `DATA_W`: write data (CPU `dout`).
- `rdata`, out, `DATA_W`: read data (CPU `din`).
- `gpio_out`, out, 16: GPIO register.
- `uart_tx`, out, 1: serial output, 8N1, LSB first, idles high.

## Operation
- Address map:
  - `0x0000_0000` to `RAM_WORDS-1`: RAM.
  - `0x8000_0000`: GPIO, read/write. Write loads `wdata[15:0]`; read returns the value zero-extended.
  - `0x8000_0001`: TX data. A write pushes `wdata[7:0]`. A read returns 0.
  - `0x8000_0002`: STATUS, read-only except bit 3.
    - bit0 = FIFO full; bit1 = FIFO empty; bit2 = serializer busy.
    - bit3 = overflow, sticky. Any write to STATUS clears it.
    - bits[7:4] = FIFO count. All other bits are 0.
  - `0x8000_0003`: CYCLE, read-only. Free-running 32-bit counter that wraps at 2^32.
  - Any other address: reads return 0; writes are ignored.
- `write` and `read` are never asserted together. If they are, the write is performed and `rdata` is still driven.
- Reads have no side effects.
- RAM write: `mem[address[log2(RAM_WORDS)-1:0]] <= wdata`, full word, at the clock edge.
- TX push when the FIFO is full: the byte is dropped and overflow is set.
- TX push and serializer pop in the same cycle: both happen and the count is unchanged.
  - The full check uses the pre-edge count, so a push is still dropped while full even though a pop occurs in the same cycle.
- Serializer states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: when the FIFO is not empty, pop the head into the shift register and enter START.
  - Each of START, DATA×8 and STOP lasts exactly `CLKS_PER_BIT` clocks. A baud counter reloads on each bit boundary.
  - From STOP, return to IDLE. If the FIFO is not empty, pop on the same edge so the next START follows back-to-back with no idle gap.
  - busy = state ≠ IDLE.
- Reset values:
  - `gpio_out` = 0, `uart_tx` = 1, FIFO empty, overflow = 0, CYCLE = 0, serializer in IDLE.
  - `rdata` follows its combinational rule.
  - RAM contents are not reset and are undefined until written.
- Reset asserted mid-frame: `uart_tx` goes to 1 immediately (asynchronous) and the FIFO contents are discarded.

## Timing
- `rdata` is combinational from `address` and current state, with zero-cycle latency.
  - The CPU registers `read`/`address` at edge N and samples `din` at edge N+1, so `rdata` must be valid before N+1.
  - The RAM therefore uses asynchronous (distributed) read.
- Writes take effect at the first `clk` edge where `write`=1.
  - A read of the same location in the following cycle returns the new value.
- The STATUS/CYCLE value returned is the value registered before edge N+1.
- First start bit: if a push occurs at edge E into an empty FIFO while the serializer is IDLE, `uart_tx` falls at edge E+1. The pop happens at E+1.
- Frame length: 10×`CLKS_PER_BIT` clocks.

## Structure
- Shared package `bus_map_pkg`:
  - Address constants `ADDR_GPIO`, `ADDR_TXDATA`, `ADDR_STATUS`, `ADDR_CYCLE`, `IO_BASE`.
  - Status bit indices.
  - Serializer state enum.
- Sub-module `uart_tx_buf` (FIFO plus serializer):
  - Ports: `push`, `push_data[7:0]`, `full`, `empty`, `count`, `busy`, `tx`.
- The top level holds the RAM, decode, GPIO, CYCLE, overflow and the read mux.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → immediately `gpio_out`=0, `uart_tx`=1; a STATUS read returns 0x0000_0002; a CYCLE read right after release returns a small count (≤ 2).
- **RAM:** write 0xDEAD_BEEF to 0x5, then 0x1234_5678 to 0x405 with `RAM_WORDS`=1024 → reading 0x5 returns 0x1234_5678 (alias); reading 0x6 after a write of 0 returns 0.
- **GPIO and unmapped:** write 0xFFFF_A5A5 to 0x8000_0000 → `gpio_out`=0xA5A5 and a read returns 0x0000_A5A5; a read of 0x8000_0010 returns 0.
- **UART frame** (`CLKS_PER_BIT`=4): push 0x55 → `uart_tx` shows 0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks; status busy=1 throughout, then 0.
- **FIFO overflow:** 10 back-to-back pushes 0x00 to 0x09 with `FIFO_DEPTH`=8 while the serializer is busy → the first pops immediately, so 0x09 is dropped and overflow=1; bytes 0x00 to 0x08 appear in order. A write to STATUS clears overflow.
- **Mid-frame reset:** push 0xA3, assert `rst` during DATA bit 3 → `uart_tx`=1 at once; after release, STATUS=0x0000_0002 and no further frame is sent.
